edge_point_extractor: RTL and testbench
=======================================

// Module: edge_point_extractor
// PURPOSE
//  Consumes the raw pixel stream from the input handler (Pixel/Frame/Line) and
//  tracks the (x,y) position of each pixel. It thresholds each pixel and emits
//  the coordinates of every pixel at or above threshold as an edge point.
//  Points are buffered in a small FIFO and offered downstream to the Hough
//  accumulator on a valid/ready handshake. Flags report end of frame, dropped
//  points and geometry errors.
// PARAMETERS
//  WIDTH       640  active pixels per line
//  HEIGHT      480  active lines per frame
//  XW          10   x coordinate width, clog2(WIDTH)
//  YW          9    y coordinate width, clog2(HEIGHT)
//  FIFO_DEPTH  16   point FIFO entries; power of two, >=2
// PORTS
//  Clk         in   1     clock; all logic on the rising edge
//  Reset       in   1     synchronous, active-high reset
//  Pixel       in   8     pixel intensity; valid when Frame && Line
//  Frame       in   1     high for the whole active frame
//  Line        in   1     high for each active line inside Frame
//  Threshold   in   8     edge threshold; sampled each valid pixel
//  PointX      out  XW    x of FIFO head point
//  PointY      out  YW    y of FIFO head point
//  PointValid  out  1     FIFO head holds a point
//  PointReady  in   1     downstream accepts; pop when PointValid && PointReady
//  FrameDone   out  1     1-cycle pulse after the frame ends
//  Dropped     out  1     sticky: >=1 point lost to a full FIFO in this frame
//  GeomErr     out  1     sticky: line/frame longer than WIDTH/HEIGHT
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, x=y=0, FSM=WAIT_FRAME.
//  Reset mid-frame flushes the FIFO. Stream resumes at the next Frame rise.
//  FSM states:
//   WAIT_FRAME: a Frame 0->1 edge clears x, y, Dropped and GeomErr and enters IN_FRAME.
//   IN_FRAME:   Frame 1->0 moves to FRAME_END.
//   FRAME_END:  FrameDone=1 for exactly this cycle, then WAIT_FRAME.
//               A Frame rise in this same cycle starts the next frame directly.
//  Pixel counting (IN_FRAME only):
//   - Each Frame&&Line cycle is one pixel at the current (x,y); then x++.
//   - Line 1->0 sets x=0 and y++.
//   - x saturates at WIDTH-1 and y saturates at HEIGHT-1.
//   - Any pixel with x or y beyond its limit sets GeomErr and is not emitted.
//  Edge test: Pixel >= Threshold (unsigned 8-bit). Threshold=0 makes every pixel an edge.
//  Latency: a pixel valid in cycle t is registered at the edge ending t and
//   written to the FIFO at the edge ending t+1.
//   PointValid is first seen in t+2 when the FIFO was empty. The FIFO is
//   first-word-fall-through with registered outputs.
//  Handshake:
//   - PointX/PointY stay stable while PointValid && !PointReady.
//   - PointValid never drops without a pop.
//  FIFO boundaries:
//   - Full with no pop: the incoming point is discarded and Dropped=1.
//   - Full with a pop in the same cycle: the point is accepted and the count is unchanged.
//   - Empty: PointReady is ignored.
//  Pixels with Frame=0 or Line=0 are ignored. Points already queued drain
//   in any state.
// STRUCTURE
//  Shared package hough_pkg holds:
//   - XW/YW defaults, WIDTH/HEIGHT
//   - point record {x,y}
//   - FSM state encodings (WAIT_FRAME=0, IN_FRAME=1, FRAME_END=2)
//  One natural sub-module: point_fifo (sync FWFT, DEPTH/data-width params,
//   push/pop/full/empty). Counters, FSM and threshold stay in this block.
// TESTING
//  1. WIDTH=4, HEIGHT=2, Threshold=0x80, pixels 0x80,0x7F,0xFF,0x00 on
//     both lines -> points (0,0),(2,0),(0,1),(2,1) in order.
//     FrameDone pulses once, 1 cycle after Frame falls.
//  2. Single edge pixel valid in cycle t with PointReady=1 ->
//     PointValid=1 in t+2, (0,0) popped, PointValid=0 in t+3.
//  3. FIFO_DEPTH=4, PointReady=0, 6 edge pixels -> first 4 points kept,
//     Dropped=1. Raise PointReady -> 4 points drain in order.
//     Dropped clears at the next Frame rise.
//  4. Line held for WIDTH+2 pixels -> GeomErr=1, exactly WIDTH points
//     emitted for that line, next line starts at x=0, y=1.
//  5. Reset asserted for 1 cycle mid-frame with 3 points queued ->
//     PointValid=0 next cycle. No points until Frame rises again,
//     first point then at (0,0).
//  6. Full FIFO with PointValid&&PointReady and a new edge pixel in the
//     same cycle -> point accepted, Dropped stays 0.

Source files
------------

// File: rtl/hough_pkg.sv
// Shared definitions for the Hough front end: default geometry, point record and
// frame-tracking FSM encodings.
package hough_pkg;

    localparam int unsigned HOUGH_WIDTH  = 640;
    localparam int unsigned HOUGH_HEIGHT = 480;
    localparam int unsigned HOUGH_XW     = 10;
    localparam int unsigned HOUGH_YW     = 9;

    typedef struct packed {
        logic [HOUGH_XW-1:0] x;
        logic [HOUGH_YW-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        StWaitFrame = 2'd0,
        StInFrame   = 2'd1,
        StFrameEnd  = 2'd2
    } frame_state_e;

endpackage

// File: rtl/point_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is read straight from the
// storage registers, so outputs carry no combinational path from the inputs.
module point_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 19
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FullCount);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot on the same edge, so a full FIFO still takes the push.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/edge_point_extractor.sv
// Tracks pixel coordinates within a frame, thresholds each pixel and queues the
// coordinates of edge pixels for the Hough accumulator.
module edge_point_extractor
    import hough_pkg::*;
#(
    parameter int unsigned WIDTH      = HOUGH_WIDTH,
    parameter int unsigned HEIGHT     = HOUGH_HEIGHT,
    parameter int unsigned XW         = HOUGH_XW,
    parameter int unsigned YW         = HOUGH_YW,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [7:0]    Pixel,
    input  logic          Frame,
    input  logic          Line,
    input  logic [7:0]    Threshold,
    output logic [XW-1:0] PointX,
    output logic [YW-1:0] PointY,
    output logic          PointValid,
    input  logic          PointReady,
    output logic          FrameDone,
    output logic          Dropped,
    output logic          GeomErr
);

    localparam logic [XW-1:0] XMax = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMax = YW'(HEIGHT - 1);

    frame_state_e  state_q, state_d;
    logic          frame_q, line_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_ovf_q, x_ovf_d, y_ovf_q, y_ovf_d;
    logic          dropped_q, dropped_d, geom_err_q, geom_err_d;
    logic          pt_valid_q, pt_valid_d;
    logic [XW-1:0] pt_x_q;
    logic [YW-1:0] pt_y_q;
    logic          frame_rise, pixel_valid, line_fall, is_edge;
    logic          fifo_full, fifo_empty;
    logic [XW+YW-1:0] fifo_rdata;

    assign frame_rise  = Frame && !frame_q;
    assign pixel_valid = Frame && Line && (state_q == StInFrame);
    assign line_fall   = line_q && !Line && (state_q == StInFrame);
    assign is_edge     = (Pixel >= Threshold);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        x_ovf_d    = x_ovf_q;
        y_ovf_d    = y_ovf_q;
        dropped_d  = dropped_q;
        geom_err_d = geom_err_q;
        pt_valid_d = 1'b0;

        if (pt_valid_q && fifo_full && !PointReady) begin
            dropped_d = 1'b1;
        end

        unique case (state_q)
            StWaitFrame, StFrameEnd: begin
                state_d = StWaitFrame;
                if (frame_rise) begin
                    state_d    = StInFrame;
                    x_d        = '0;
                    y_d        = '0;
                    x_ovf_d    = 1'b0;
                    y_ovf_d    = 1'b0;
                    dropped_d  = 1'b0;
                    geom_err_d = 1'b0;
                end
            end
            StInFrame: begin
                if (!Frame) begin
                    state_d = StFrameEnd;
                end
                // Overflow flags mark a coordinate that has already used its last legal value.
                if (pixel_valid) begin
                    if (x_ovf_q || y_ovf_q) begin
                        geom_err_d = 1'b1;
                    end else begin
                        pt_valid_d = is_edge;
                        if (x_q == XMax) x_ovf_d = 1'b1;
                        else             x_d     = x_q + 1'b1;
                    end
                end
                if (line_fall) begin
                    x_d     = '0;
                    x_ovf_d = 1'b0;
                    if (y_q == YMax) y_ovf_d = 1'b1;
                    else             y_d     = y_q + 1'b1;
                end
            end
            default: state_d = StWaitFrame;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StWaitFrame;
            // Treat Frame as already high so a reset inside a frame cannot fake a rise.
            frame_q    <= 1'b1;
            line_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            x_ovf_q    <= 1'b0;
            y_ovf_q    <= 1'b0;
            dropped_q  <= 1'b0;
            geom_err_q <= 1'b0;
            pt_valid_q <= 1'b0;
            pt_x_q     <= '0;
            pt_y_q     <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= Frame;
            line_q     <= Line;
            x_q        <= x_d;
            y_q        <= y_d;
            x_ovf_q    <= x_ovf_d;
            y_ovf_q    <= y_ovf_d;
            dropped_q  <= dropped_d;
            geom_err_q <= geom_err_d;
            pt_valid_q <= pt_valid_d;
            pt_x_q     <= x_q;
            pt_y_q     <= y_q;
        end
    end

    point_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (XW + YW)
    ) u_point_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .push_i  (pt_valid_q),
        .wdata_i ({pt_x_q, pt_y_q}),
        .pop_i   (PointReady),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign PointX     = fifo_rdata[XW+YW-1:YW];
    assign PointY     = fifo_rdata[YW-1:0];
    assign PointValid = !fifo_empty;
    assign FrameDone  = (state_q == StFrameEnd);
    assign Dropped    = dropped_q;
    assign GeomErr    = geom_err_q;

endmodule

// File: tb/tb_edge_point_extractor.sv
// Directed bench for edge_point_extractor on a 4x2 frame with a 4-entry point FIFO.
module tb_edge_point_extractor;

    localparam int unsigned W     = 4;
    localparam int unsigned H     = 2;
    localparam int unsigned XW    = 10;
    localparam int unsigned YW    = 9;
    localparam int unsigned DEPTH = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [7:0]    Pixel, Threshold;
    logic          Frame, Line, PointReady;
    logic [XW-1:0] PointX;
    logic [YW-1:0] PointY;
    logic          PointValid, FrameDone, Dropped, GeomErr;

    int checks = 0;
    int errors = 0;
    logic [XW+YW-1:0] popped [$];
    int done_cnt = 0;
    int qbase, dbase;

    edge_point_extractor #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .XW         (XW),
        .YW         (YW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Pixel      (Pixel),
        .Frame      (Frame),
        .Line       (Line),
        .Threshold  (Threshold),
        .PointX     (PointX),
        .PointY     (PointY),
        .PointValid (PointValid),
        .PointReady (PointReady),
        .FrameDone  (FrameDone),
        .Dropped    (Dropped),
        .GeomErr    (GeomErr)
    );

    initial forever #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (PointValid && PointReady) popped.push_back({PointX, PointY});
        if (FrameDone) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [XW+YW-1:0] pt(input int x, input int y);
        return {XW'(x), YW'(y)};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pixel(input logic [7:0] p);
        Line  = 1'b1;
        Pixel = p;
        tick();
    endtask

    task automatic check_points(input string tag, input int n, input logic [XW+YW-1:0] exp [8]);
        logic [XW+YW-1:0] got;
        check({tag, " count"}, 32'(popped.size() - qbase), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = (qbase + i < popped.size()) ? popped[qbase + i] : '1;
            check($sformatf("%s pt%0d", tag, i), 32'(got), 32'(exp[i]));
        end
    endtask

    initial begin
        Reset = 1'b1; Frame = 1'b0; Line = 1'b0; Pixel = 8'h00;
        Threshold = 8'h80; PointReady = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        check("reset PointValid", 32'(PointValid), 32'd0);
        check("reset PointX", 32'(PointX), 32'd0);
        check("reset PointY", 32'(PointY), 32'd0);
        check("reset FrameDone", 32'(FrameDone), 32'd0);
        check("reset Dropped", 32'(Dropped), 32'd0);
        check("reset GeomErr", 32'(GeomErr), 32'd0);
        tick();

        // 1: threshold at 0x80 over two lines
        qbase = popped.size(); dbase = done_cnt;
        Frame = 1'b1; tick();
        for (int l = 0; l < 2; l++) begin
            pixel(8'h80); pixel(8'h7F); pixel(8'hFF); pixel(8'h00);
            Line = 1'b0; tick();
        end
        Frame = 1'b0; tick();
        check("t1 FrameDone pulse", 32'(FrameDone), 32'd1);
        tick();
        check("t1 FrameDone low", 32'(FrameDone), 32'd0);
        repeat (6) tick();
        check_points("t1", 4, '{pt(0,0), pt(2,0), pt(0,1), pt(2,1), '0, '0, '0, '0});
        check("t1 FrameDone count", 32'(done_cnt - dbase), 32'd1);
        check("t1 GeomErr", 32'(GeomErr), 32'd0);
        check("t1 Dropped", 32'(Dropped), 32'd0);

        // 2: single-pixel latency
        qbase = popped.size();
        Frame = 1'b1; tick();
        Line = 1'b1; Pixel = 8'hFF; tick();
        Line = 1'b0; Pixel = 8'h00;
        check("t2 valid t+1", 32'(PointValid), 32'd0);
        tick();
        check("t2 valid t+2", 32'(PointValid), 32'd1);
        check("t2 x t+2", 32'(PointX), 32'd0);
        check("t2 y t+2", 32'(PointY), 32'd0);
        tick();
        check("t2 valid t+3", 32'(PointValid), 32'd0);
        Frame = 1'b0; repeat (4) tick();
        check_points("t2", 1, '{pt(0,0), '0, '0, '0, '0, '0, '0, '0});

        // 3: overflow with PointReady low
        qbase = popped.size(); PointReady = 1'b0;
        Frame = 1'b1; tick();
        repeat (4) pixel(8'hFF);
        Line = 1'b0; tick();
        repeat (2) pixel(8'hFF);
        Line = 1'b0; repeat (4) tick();
        check("t3 Dropped set", 32'(Dropped), 32'd1);
        check("t3 valid held", 32'(PointValid), 32'd1);
        check("t3 head x", 32'(PointX), 32'd0);
        check("t3 GeomErr", 32'(GeomErr), 32'd0);
        Frame = 1'b0; repeat (3) tick();
        PointReady = 1'b1; repeat (6) tick();
        check_points("t3", 4, '{pt(0,0), pt(1,0), pt(2,0), pt(3,0), '0, '0, '0, '0});
        check("t3 drained", 32'(PointValid), 32'd0);
        check("t3 Dropped sticky", 32'(Dropped), 32'd1);
        Frame = 1'b1; tick();
        check("t3 Dropped cleared", 32'(Dropped), 32'd0);

        // 4: overlong line
        qbase = popped.size(); Threshold = 8'h00;
        repeat (W + 2) pixel(8'h00);
        Line = 1'b0; tick();
        check("t4 GeomErr set", 32'(GeomErr), 32'd1);
        pixel(8'h00);
        Line = 1'b0; tick();
        Frame = 1'b0; repeat (5) tick();
        check_points("t4", 5, '{pt(0,0), pt(1,0), pt(2,0), pt(3,0), pt(0,1), '0, '0, '0});
        check("t4 GeomErr sticky", 32'(GeomErr), 32'd1);

        // 5: reset mid-frame with points queued
        Frame = 1'b1; tick();
        check("t5 GeomErr cleared", 32'(GeomErr), 32'd0);
        PointReady = 1'b0;
        repeat (3) pixel(8'h10);
        Line = 1'b0; repeat (3) tick();
        check("t5 queued", 32'(PointValid), 32'd1);
        Reset = 1'b1; tick();
        Reset = 1'b0;
        check("t5 flushed", 32'(PointValid), 32'd0);
        qbase = popped.size(); dbase = done_cnt; PointReady = 1'b1;
        repeat (2) pixel(8'hFF);
        Line = 1'b0; repeat (4) tick();
        check("t5 ignored mid-frame", 32'(PointValid), 32'd0);
        Frame = 1'b0; repeat (3) tick();
        check("t5 no FrameDone", 32'(done_cnt - dbase), 32'd0);
        Frame = 1'b1; tick();
        pixel(8'hFF);
        Line = 1'b0; repeat (3) tick();
        Frame = 1'b0; repeat (3) tick();
        check_points("t5", 1, '{pt(0,0), '0, '0, '0, '0, '0, '0, '0});

        // 6: full FIFO with pop and push on the same edge
        qbase = popped.size(); PointReady = 1'b0;
        Frame = 1'b1; tick();
        repeat (4) pixel(8'h55);
        Line = 1'b0; repeat (3) tick();
        check("t6 full valid", 32'(PointValid), 32'd1);
        check("t6 full Dropped", 32'(Dropped), 32'd0);
        Line = 1'b1; Pixel = 8'h55; tick();
        Line = 1'b0; PointReady = 1'b1; tick();
        PointReady = 1'b0;
        check("t6 Dropped after pop+push", 32'(Dropped), 32'd0);
        check("t6 head x", 32'(PointX), 32'd1);
        check("t6 head y", 32'(PointY), 32'd0);
        Frame = 1'b0; tick();
        PointReady = 1'b1; repeat (8) tick();
        check_points("t6", 5, '{pt(0,0), pt(1,0), pt(2,0), pt(3,0), pt(0,1), '0, '0, '0});
        check("t6 Dropped end", 32'(Dropped), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
